// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for one port of the SRAM arbiter.
interface sram_arbiter_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16
);
   logic              req;
   logic              we;
   logic [1:0]        be;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, be, addr, wdata, input rdata, ack);
   modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous 16-bit SRAM between CPU (port 0)
// and debug/loader (port 1), with setup/strobe/hold sequencing and registered pins.
module sram_arbiter #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   sram_arbiter_if.slave     r0,
   sram_arbiter_if.slave     r1,
   output logic [ADDR_W-1:0] ADDR,
   output logic              CE,
   output logic              UB,
   output logic              LB,
   output logic              OE,
   output logic              WE,
   output logic [DATA_W-1:0] dq_out,
   output logic              dq_oe,
   input  logic [DATA_W-1:0] dq_in,
   output logic              busy,
   output logic              grant
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   typedef struct packed {
      logic              we;
      logic [1:0]        be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state, state_d;
   req_t              lat, lat_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              grant_d;
   logic              sel;
   logic              ack0_q, ack1_q, ack0_d, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata1_q, rdata0_d, rdata1_d;

   logic [ADDR_W-1:0] addr_d;
   logic              ce_d, ub_d, lb_d, oe_d, we_d, dq_oe_d, busy_d;
   logic [DATA_W-1:0] dq_out_d;

   assign r0.ack   = ack0_q;
   assign r1.ack   = ack1_q;
   assign r0.rdata = rdata0_q;
   assign r1.rdata = rdata1_q;

   // Next state, latched request, and pin values for the state being entered
   always_comb begin
      state_d  = state;
      lat_d    = lat;
      cnt_d    = cnt;
      grant_d  = grant;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      sel      = (r0.req && r1.req) ? ~grant : r1.req;

      unique case (state)
         IDLE: begin
            if (r0.req || r1.req) begin
               grant_d = sel;
               lat_d   = sel ? '{we: r1.we, be: r1.be, addr: r1.addr, wdata: r1.wdata}
                             : '{we: r0.we, be: r0.be, addr: r0.addr, wdata: r0.wdata};
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt == CNT_W'(1)) begin
               if (!lat.we) begin
                  if (grant) rdata1_d = dq_in;
                  else       rdata0_d = dq_in;
               end
               ack0_d  = ~grant;
               ack1_d  = grant;
               state_d = DONE;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      addr_d   = ADDR;
      dq_out_d = dq_out;
      ce_d     = 1'b1;
      ub_d     = 1'b1;
      lb_d     = 1'b1;
      oe_d     = 1'b1;
      we_d     = 1'b1;
      dq_oe_d  = 1'b0;
      busy_d   = (state_d != IDLE);

      // Pins are registered, so they are decoded from the state being entered
      unique case (state_d)
         SETUP: begin
            ce_d    = 1'b0;
            addr_d  = lat_d.addr;
            ub_d    = ~lat_d.be[1];
            lb_d    = ~lat_d.be[0];
            oe_d    = lat_d.we;
            dq_oe_d = lat_d.we;
            if (lat_d.we) dq_out_d = lat_d.wdata;
         end
         ACCESS: begin
            ce_d    = 1'b0;
            ub_d    = ~lat_d.be[1];
            lb_d    = ~lat_d.be[0];
            oe_d    = lat_d.we;
            we_d    = ~lat_d.we;
            dq_oe_d = lat_d.we;
         end
         DONE: begin
            ce_d    = 1'b0;
            ub_d    = ~lat_d.be[1];
            lb_d    = ~lat_d.be[0];
            dq_oe_d = lat_d.we;
         end
         default: ;
      endcase
   end

   // State and registered outputs; reset aborts any transaction without an ack
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= IDLE;
         lat      <= '0;
         cnt      <= '0;
         grant    <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ADDR     <= '0;
         CE       <= 1'b1;
         UB       <= 1'b1;
         LB       <= 1'b1;
         OE       <= 1'b1;
         WE       <= 1'b1;
         dq_out   <= '0;
         dq_oe    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         lat      <= lat_d;
         cnt      <= cnt_d;
         grant    <= grant_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ADDR     <= addr_d;
         CE       <= ce_d;
         UB       <= ub_d;
         LB       <= lb_d;
         OE       <= oe_d;
         WE       <= we_d;
         dq_out   <= dq_out_d;
         dq_oe    <= dq_oe_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at WAIT_CYCLES=2, one at 1, each with an SRAM model.
module tb_sram_arbiter;

   logic Clk = 1'b0;
   logic Reset;
   int   n_asrt = 0;
   int   n_fail = 0;

   always #5 Clk = ~Clk;

   sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) a0 ();
   sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) a1 ();
   sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) b0 ();
   sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) b1 ();

   logic [19:0] a_addr, b_addr;
   logic        a_ce, a_ub, a_lb, a_oe, a_we, a_dq_oe, a_busy, a_grant;
   logic        b_ce, b_ub, b_lb, b_oe, b_we, b_dq_oe, b_busy, b_grant;
   logic [15:0] a_dq_out, a_dq_in, b_dq_out, b_dq_in;

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) u_a (
      .Clk(Clk), .Reset(Reset), .r0(a0), .r1(a1),
      .ADDR(a_addr), .CE(a_ce), .UB(a_ub), .LB(a_lb), .OE(a_oe), .WE(a_we),
      .dq_out(a_dq_out), .dq_oe(a_dq_oe), .dq_in(a_dq_in), .busy(a_busy), .grant(a_grant));

   sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) u_b (
      .Clk(Clk), .Reset(Reset), .r0(b0), .r1(b1),
      .ADDR(b_addr), .CE(b_ce), .UB(b_ub), .LB(b_lb), .OE(b_oe), .WE(b_we),
      .dq_out(b_dq_out), .dq_oe(b_dq_oe), .dq_in(b_dq_in), .busy(b_busy), .grant(b_grant));

   // SRAM models: byte-lane writes while CE and WE are low, async read while CE and OE are low
   logic [15:0] mem_a [0:2047];
   logic [15:0] mem_b [0:2047];

   always @(posedge Clk) begin
      if (!Reset) begin
         mem_a[11'h013] <= 16'h5A5A;
         mem_a[11'h400] <= 16'hFF00;
      end else if (!a_ce && !a_we) begin
         if (!a_lb) mem_a[a_addr[10:0]][7:0]  <= a_dq_out[7:0];
         if (!a_ub) mem_a[a_addr[10:0]][15:8] <= a_dq_out[15:8];
      end
   end

   always @(posedge Clk) begin
      if (!Reset) begin
         mem_b[11'h013] <= 16'h3C3C;
      end else if (!b_ce && !b_we) begin
         if (!b_lb) mem_b[b_addr[10:0]][7:0]  <= b_dq_out[7:0];
         if (!b_ub) mem_b[b_addr[10:0]][15:8] <= b_dq_out[15:8];
      end
   end

   assign a_dq_in = (!a_ce && !a_oe) ? mem_a[a_addr[10:0]] : 16'hDEAD;
   assign b_dq_in = (!b_ce && !b_oe) ? mem_b[b_addr[10:0]] : 16'hDEAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // WE and OE must never be low together
   always @(negedge Clk) begin
      chk("a_we_oe_excl", 32'(a_we | a_oe), 1);
      chk("b_we_oe_excl", 32'(b_we | b_oe), 1);
   end

   task automatic set_req(input bit on_b, input bit port, input bit req, input bit we,
                          input logic [1:0] be, input logic [19:0] addr, input logic [15:0] wdata);
      if (!on_b && !port) begin a0.req = req; a0.we = we; a0.be = be; a0.addr = addr; a0.wdata = wdata; end
      if (!on_b &&  port) begin a1.req = req; a1.we = we; a1.be = be; a1.addr = addr; a1.wdata = wdata; end
      if ( on_b && !port) begin b0.req = req; b0.we = we; b0.be = be; b0.addr = addr; b0.wdata = wdata; end
      if ( on_b &&  port) begin b1.req = req; b1.we = we; b1.be = be; b1.addr = addr; b1.wdata = wdata; end
   endtask

   // Waits (bounded) for the ack of one port; counts strobe cycles and lane/data violations
   task automatic txn_wait(input bit on_b, input bit port, input bit drop, input bit is_wr,
                           input logic exp_ub, input logic exp_lb, input logic [15:0] exp_dq,
                           output int cyc, output int we_lo, output int oe_lo, output int bad);
      logic ce, ub, lb, oe, we, dqoe, ack;
      logic [15:0] dqo;
      cyc = -1; we_lo = 0; oe_lo = 0; bad = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         ce   = on_b ? b_ce : a_ce;
         ub   = on_b ? b_ub : a_ub;
         lb   = on_b ? b_lb : a_lb;
         oe   = on_b ? b_oe : a_oe;
         we   = on_b ? b_we : a_we;
         dqoe = on_b ? b_dq_oe : a_dq_oe;
         dqo  = on_b ? b_dq_out : a_dq_out;
         ack  = on_b ? (port ? b1.ack : b0.ack) : (port ? a1.ack : a0.ack);
         if (!we) we_lo++;
         if (!oe) oe_lo++;
         if (!ce && (ub !== exp_ub || lb !== exp_lb)) bad++;
         if (dqoe && (!is_wr || dqo !== exp_dq)) bad++;
         if (ack === 1'b1) begin
            cyc = i;
            if (drop) begin
               if (!on_b && !port) a0.req = 1'b0;
               if (!on_b &&  port) a1.req = 1'b0;
               if ( on_b && !port) b0.req = 1'b0;
               if ( on_b &&  port) b1.req = 1'b0;
            end
            break;
         end
      end
   endtask

   initial begin
      int cyc, we_lo, oe_lo, bad;
      Reset = 1'b0;
      set_req(0, 0, 0, 0, 2'b00, 20'h0, 16'h0);
      set_req(0, 1, 0, 0, 2'b00, 20'h0, 16'h0);
      set_req(1, 0, 0, 0, 2'b00, 20'h0, 16'h0);
      set_req(1, 1, 0, 0, 2'b00, 20'h0, 16'h0);
      tick(); tick(); tick();

      // Reset state
      chk("rst_ce", 32'(a_ce), 1);
      chk("rst_we", 32'(a_we), 1);
      chk("rst_oe", 32'(a_oe), 1);
      chk("rst_ublb", 32'({a_ub, a_lb}), 3);
      chk("rst_addr", 32'(a_addr), 0);
      chk("rst_dq", 32'({a_dq_oe, a_dq_out}), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_grant", 32'(a_grant), 1);
      chk("rst_ack", 32'({a0.ack, a1.ack}), 0);
      chk("rst_rdata", 32'({a0.rdata, a1.rdata}), 0);
      Reset = 1'b1;
      tick();

      // 1: port 0 write then read back
      set_req(0, 0, 1, 1, 2'b11, 20'h00012, 16'hBEEF);
      txn_wait(0, 0, 1, 1, 1'b0, 1'b0, 16'hBEEF, cyc, we_lo, oe_lo, bad);
      chk("t1w_latency", cyc, 4);
      chk("t1w_we_lo", we_lo, 2);
      chk("t1w_oe_lo", oe_lo, 0);
      chk("t1w_bad", bad, 0);
      chk("t1w_done_pins", 32'({a_ce, a_we, a_oe, a_dq_oe, a_busy, a_grant}), 32'b011110);
      tick();
      chk("t1w_idle_pins", 32'({a_ce, a_ub, a_lb, a_dq_oe, a_busy, a0.ack}), 32'b111000);
      set_req(0, 0, 1, 0, 2'b11, 20'h00012, 16'h0000);
      txn_wait(0, 0, 1, 0, 1'b0, 1'b0, 16'h0000, cyc, we_lo, oe_lo, bad);
      chk("t1r_latency", cyc, 4);
      chk("t1r_oe_lo", oe_lo, 3);
      chk("t1r_we_lo", we_lo, 0);
      chk("t1r_bad", bad, 0);
      chk("t1r_rdata", 32'(a0.rdata), 32'hBEEF);
      chk("t1r_other_rdata", 32'(a1.rdata), 0);
      tick();

      // 2: simultaneous reads right after reset
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      set_req(0, 0, 1, 0, 2'b11, 20'h00012, 16'h0);
      set_req(0, 1, 1, 0, 2'b11, 20'h00013, 16'h0);
      txn_wait(0, 0, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t2_p0_latency", cyc, 4);
      chk("t2_p0_grant", 32'(a_grant), 0);
      chk("t2_p0_rdata", 32'(a0.rdata), 32'hBEEF);
      txn_wait(0, 1, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t2_p1_latency", cyc, 5);
      chk("t2_p1_grant", 32'(a_grant), 1);
      chk("t2_p1_rdata", 32'(a1.rdata), 32'h5A5A);
      chk("t2_p0_rdata_kept", 32'(a0.rdata), 32'hBEEF);
      chk("t2_bad", bad, 0);
      tick();

      // 3: port 0 held high, port 1 requests once -> grants 0,1,0
      set_req(0, 0, 1, 0, 2'b11, 20'h00012, 16'h0);
      set_req(0, 1, 1, 0, 2'b11, 20'h00013, 16'h0);
      txn_wait(0, 0, 0, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t3_a_latency", cyc, 4);
      chk("t3_a_grant", 32'(a_grant), 0);
      txn_wait(0, 1, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t3_b_latency", cyc, 5);
      chk("t3_b_grant", 32'(a_grant), 1);
      txn_wait(0, 0, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t3_c_latency", cyc, 5);
      chk("t3_c_grant", 32'(a_grant), 0);
      chk("t3_bad", bad, 0);
      tick();

      // 4: lower-byte-only write on port 1, then read back the merged word
      set_req(0, 1, 1, 1, 2'b01, 20'h00400, 16'h12AB);
      txn_wait(0, 1, 1, 1, 1'b1, 1'b0, 16'h12AB, cyc, we_lo, oe_lo, bad);
      chk("t4w_latency", cyc, 4);
      chk("t4w_we_lo", we_lo, 2);
      chk("t4w_lane_dq_bad", bad, 0);
      chk("t4w_grant", 32'(a_grant), 1);
      tick();
      set_req(0, 1, 1, 0, 2'b11, 20'h00400, 16'h0);
      txn_wait(0, 1, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t4r_latency", cyc, 4);
      chk("t4r_rdata", 32'(a1.rdata), 32'hFFAB);
      tick();

      // be = 00 still runs a full cycle with both lanes off
      set_req(0, 0, 1, 1, 2'b00, 20'h00030, 16'h1111);
      txn_wait(0, 0, 1, 1, 1'b1, 1'b1, 16'h1111, cyc, we_lo, oe_lo, bad);
      chk("be00_latency", cyc, 4);
      chk("be00_bad", bad, 0);
      tick();

      // 5: reset during the second ACCESS cycle of a write
      set_req(0, 0, 1, 1, 2'b11, 20'h00020, 16'h7777);
      tick();
      chk("t5_setup", 32'({a_ce, a_busy, a_grant, a_dq_oe, a_we, a_oe}), 32'b010111);
      chk("t5_setup_addr", 32'(a_addr), 32'h20);
      chk("t5_setup_dq", 32'(a_dq_out), 32'h7777);
      tick();
      chk("t5_acc1_we", 32'(a_we), 0);
      tick();
      chk("t5_acc2_we", 32'(a_we), 0);
      Reset = 1'b0;
      tick();
      chk("t5_abort_pins", 32'({a_ce, a_we, a_oe, a_dq_oe, a_busy}), 32'b11100);
      chk("t5_abort_ack", 32'(a0.ack), 0);
      chk("t5_abort_grant", 32'(a_grant), 1);
      chk("t5_abort_rdata", 32'(a1.rdata), 0);
      a0.req = 1'b0;
      tick();
      chk("t5_abort_ack2", 32'(a0.ack), 0);
      Reset = 1'b1;
      tick();
      chk("t5_idle", 32'({a0.ack, a_busy}), 0);
      set_req(0, 1, 1, 0, 2'b11, 20'h00013, 16'h0);
      txn_wait(0, 1, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t5_p1_latency", cyc, 4);
      chk("t5_p1_rdata", 32'(a1.rdata), 32'h5A5A);
      chk("t5_p1_grant", 32'(a_grant), 1);
      tick();

      // 6: WAIT_CYCLES = 1 instance, read on port 1
      set_req(1, 1, 1, 0, 2'b11, 20'h00013, 16'h0);
      txn_wait(1, 1, 1, 0, 1'b0, 1'b0, 16'h0, cyc, we_lo, oe_lo, bad);
      chk("t6_latency", cyc, 3);
      chk("t6_oe_lo", oe_lo, 2);
      chk("t6_we_lo", we_lo, 0);
      chk("t6_bad", bad, 0);
      chk("t6_rdata", 32'(b1.rdata), 32'h3C3C);
      chk("t6_grant", 32'(b_grant), 1);
      tick();
      chk("t6_idle", 32'({b_ce, b_busy, b1.ack}), 32'b100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM (CE/UB/LB/OE/WE, all active-low) between two requesters: port 0 is the CPU memory path and port 1 is the debug/loader port.
- Sequences each access through a fixed setup/strobe/hold timing with programmable wait states.
- Grants by round-robin and drives the tri-state data controls; the top level owns the inout pad.
- Sits between CPU/Mem2IO and the physical SRAM pins.

Parameters:
ADDR_W, 20, address width
DATA_W, 16, data width
WAIT_CYCLES, 2, strobe-phase cycles per access; legal range 1..15

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-low reset
r0_req  input  1  port 0 request; held with its qualifiers until r0_ack
r0_we  input  1  1 = write, 0 = read
r0_be  input  2  byte enables, [1] = upper byte, [0] = lower byte
r0_addr  input  ADDR_W  word address
r0_wdata  input  DATA_W  write data
r0_rdata  output  DATA_W  read data, valid when r0_ack = 1
r0_ack  output  1  one-cycle completion pulse
r1_req, r1_we, r1_be, r1_addr, r1_wdata, r1_rdata, r1_ack: same as port 0, for port 1
ADDR  output  ADDR_W  SRAM address
CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low
dq_out  output  DATA_W  data driven toward the pad
dq_oe  output  1  pad driver enable
dq_in  input  DATA_W  data returned from the pad
busy  output  1  high in every state other than IDLE
grant  output  1  owner of the current or most recent transaction

Behaviour:
- All outputs are registered. All state changes occur on the rising edge of Clk.
- Reset (Reset = 0 at an edge):
  - state = IDLE; CE = UB = LB = OE = WE = 1; ADDR = 0; dq_out = 0; dq_oe = 0.
  - r0_ack = r1_ack = 0; r0_rdata = r1_rdata = 0; busy = 0; grant = 1, so port 0 wins the first tie.
  - Reset in any state aborts the transaction. No ack is issued for an aborted transaction. All strobes are deasserted on that same edge.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the port that is not equal to grant (round-robin).
  - On grant: latch we, be, addr and wdata from the granted port; update grant; go to SETUP.
  - No request: stay in IDLE, strobes high.
- SETUP (1 cycle):
  - CE = 0; ADDR = latched address; UB = ~be[1]; LB = ~be[0]; WE = 1.
  - Read: OE = 0, dq_oe = 0.
  - Write: OE = 1, dq_oe = 1, dq_out = latched wdata.
  - Load the wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS (exactly WAIT_CYCLES cycles):
  - Write: WE = 0 and dq_oe = 1.
  - Read: OE = 0.
  - The counter decrements each cycle. On the last ACCESS cycle:
    - Read: dq_in is captured into rdata of the granted port.
    - Go to DONE.
- DONE (1 cycle):
  - WE = 1 and OE = 1. CE, ADDR, UB and LB are held.
  - Write: dq_oe stays 1 for data hold.
  - The granted port's ack = 1. The other port's ack and rdata are unchanged.
  - Next state: IDLE. On entering IDLE, CE/UB/LB = 1 and dq_oe = 0.
- Latency:
  - A request sampled in IDLE at edge k produces ack high during cycle k + 2 + WAIT_CYCLES (cycle k+4 at the default).
  - One transaction occupies 3 + WAIT_CYCLES cycles including IDLE.
- Requester rule:
  - The requester deasserts req on the edge where it samples ack = 1.
  - If req is still high in IDLE, it is treated as a new transaction with the then-current qualifiers.
- Changes to req or qualifiers of a granted port during SETUP, ACCESS or DONE have no effect.
- A request arriving for the non-granted port during a transaction waits. It is granted in the next IDLE ahead of the just-served port.
- be = 00: a full cycle is still run with UB = LB = 1, and ack is still returned.
- WE and OE are never both 0 in any cycle. dq_oe = 1 only occurs during write transactions.

Test Plan:
1. Write/read on port 0:
   - Stimulus: r0 write addr 0x00012, data 0xBEEF, be 11; then r0 read addr 0x00012, with the SRAM model returning the stored value.
   - Response: r0_ack high in cycle k+4 for each access; r0_rdata = 0xBEEF; WE low for exactly 2 cycles during the write.
2. Simultaneous requests after reset:
   - Stimulus: r0 and r1 both request reads at the same edge.
   - Response: port 0 is served first (grant = 0) and port 1 next (grant = 1); no idle gap beyond the single IDLE cycle.
3. Fairness with port 0 held high:
   - Stimulus: r0_req held high continuously while r1 requests once.
   - Response: the grant sequence alternates 0, 1, 0; r1 is acked within 2 transactions.
4. Byte-lane write:
   - Stimulus: r1 write 0x00400, data 0x12AB, be 01.
   - Response: LB = 0 and UB = 1 throughout SETUP through DONE; dq_out = 0x12AB while dq_oe = 1.
5. Reset mid-operation:
   - Stimulus: Reset = 0 during the second ACCESS cycle of a write.
   - Response: at the next edge CE = WE = OE = 1, dq_oe = 0, busy = 0, and no ack is issued.
   - Then: a subsequent port 1 request is served normally.
6. WAIT_CYCLES = 1:
   - Stimulus: a read on port 1.
   - Response: ack in cycle k+3; OE low for 2 cycles (SETUP plus ACCESS).
